// File: rtl/ddr2_arbiter.sv
// Two-port arbiter sharing one DDR2 FIFO interface between the D$ (port 0) and I$ (port 1).
// Grants one whole transaction at a time and routes read beats only to the owner.
module ddr2_arbiter #(
   parameter bit PRIO_RR = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   p0_af_cmd_din,
   input  logic [30:0]  p0_af_addr_din,
   input  logic         p0_af_wr_en,
   input  logic [127:0] p0_wdf_din,
   input  logic [15:0]  p0_wdf_mask_din,
   input  logic         p0_wdf_wr_en,
   input  logic         p0_rdf_rd_en,
   output logic         p0_af_full,
   output logic         p0_wdf_full,
   output logic         p0_rdf_valid,
   output logic [127:0] p0_rdf_dout,
   input  logic [2:0]   p1_af_cmd_din,
   input  logic [30:0]  p1_af_addr_din,
   input  logic         p1_af_wr_en,
   input  logic [127:0] p1_wdf_din,
   input  logic [15:0]  p1_wdf_mask_din,
   input  logic         p1_wdf_wr_en,
   input  logic         p1_rdf_rd_en,
   output logic         p1_af_full,
   output logic         p1_wdf_full,
   output logic         p1_rdf_valid,
   output logic [127:0] p1_rdf_dout,
   input  logic         af_full,
   input  logic         wdf_full,
   input  logic         rdf_valid,
   input  logic [127:0] rdf_dout,
   output logic [2:0]   af_cmd_din,
   output logic [30:0]  af_addr_din,
   output logic         af_wr_en,
   output logic [127:0] wdf_din,
   output logic [15:0]  wdf_mask_din,
   output logic         wdf_wr_en,
   output logic         rdf_rd_en,
   output logic         owner,
   output logic         busy
);

   typedef enum logic [1:0] {StIdle, StWr2, StRd1, StRd2} state_e;

   state_e     r_state, w_state_d;
   logic       r_owner, w_owner_d;
   logic       r_last, w_last_d;
   logic       w_win, w_win_req, w_win_wr, w_accept, w_sel;
   logic [2:0] w_win_cmd;
   logic       w_own_wdf_en, w_own_rd_en, w_wdf_push, w_rdf_pop;

   always_comb begin
      if (p0_af_wr_en && p1_af_wr_en) w_win = PRIO_RR ? ~r_last : 1'b0;
      else                            w_win = p1_af_wr_en;
   end

   assign w_win_req = w_win ? p1_af_wr_en : p0_af_wr_en;
   assign w_win_cmd = w_win ? p1_af_cmd_din : p0_af_cmd_din;
   assign w_win_wr  = (w_win_cmd == 3'b000);
   // rst gates the grant so nothing is pushed while reset is held
   assign w_accept  = rst & w_win_req & ~af_full & (~w_win_wr | ~wdf_full);

   assign w_sel        = (r_state == StIdle) ? w_win : r_owner;
   assign af_cmd_din   = w_sel ? p1_af_cmd_din   : p0_af_cmd_din;
   assign af_addr_din  = w_sel ? p1_af_addr_din  : p0_af_addr_din;
   assign wdf_din      = w_sel ? p1_wdf_din      : p0_wdf_din;
   assign wdf_mask_din = w_sel ? p1_wdf_mask_din : p0_wdf_mask_din;
   assign w_own_wdf_en = r_owner ? p1_wdf_wr_en : p0_wdf_wr_en;
   assign w_own_rd_en  = r_owner ? p1_rdf_rd_en : p0_rdf_rd_en;

   assign p0_rdf_dout = rdf_dout;
   assign p1_rdf_dout = rdf_dout;
   assign owner       = r_owner;
   assign busy        = (r_state != StIdle);
   assign wdf_wr_en   = w_wdf_push;
   assign rdf_rd_en   = w_rdf_pop;

   always_comb begin
      w_state_d    = r_state;
      w_owner_d    = r_owner;
      w_last_d     = r_last;
      af_wr_en     = 1'b0;
      w_wdf_push   = 1'b0;
      w_rdf_pop    = 1'b0;
      p0_af_full   = 1'b1;
      p0_wdf_full  = 1'b1;
      p0_rdf_valid = 1'b0;
      p1_af_full   = 1'b1;
      p1_wdf_full  = 1'b1;
      p1_rdf_valid = 1'b0;
      unique case (r_state)
         StIdle: begin
            // beats arriving with no owner are drained and dropped
            w_rdf_pop = rdf_valid & rst;
            if (w_win) begin
               p1_af_full  = af_full;
               p1_wdf_full = w_win_wr ? wdf_full : 1'b1;
            end else begin
               p0_af_full  = af_full;
               p0_wdf_full = w_win_wr ? wdf_full : 1'b1;
            end
            if (w_accept) begin
               af_wr_en   = 1'b1;
               w_wdf_push = w_win_wr;
               w_owner_d  = w_win;
               w_last_d   = w_win;
               w_state_d  = w_win_wr ? StWr2 : StRd1;
            end
         end
         StWr2: begin
            w_rdf_pop  = rdf_valid;
            w_wdf_push = w_own_wdf_en & ~wdf_full;
            if (r_owner) p1_wdf_full = wdf_full;
            else         p0_wdf_full = wdf_full;
            if (w_wdf_push) w_state_d = StIdle;
         end
         StRd1, StRd2: begin
            w_rdf_pop = w_own_rd_en & rdf_valid;
            if (r_owner) p1_rdf_valid = rdf_valid;
            else         p0_rdf_valid = rdf_valid;
            if (w_rdf_pop) w_state_d = (r_state == StRd1) ? StRd2 : StIdle;
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_owner <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_d;
         r_owner <= w_owner_d;
         r_last  <= w_last_d;
      end
   end

endmodule

// File: tb/tb_ddr2_arbiter.sv
// Bench for ddr2_arbiter: a round-robin (k=0) and a fixed-priority (k=1) instance share stimulus;
// grants are predicted by a transaction-level arbitration model.
module tb_ddr2_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [2:0]   p0_af_cmd_din, p1_af_cmd_din;
   logic [30:0]  p0_af_addr_din, p1_af_addr_din;
   logic         p0_af_wr_en, p1_af_wr_en;
   logic [127:0] p0_wdf_din, p1_wdf_din;
   logic [15:0]  p0_wdf_mask_din, p1_wdf_mask_din;
   logic         p0_wdf_wr_en, p1_wdf_wr_en, p0_rdf_rd_en, p1_rdf_rd_en;
   logic         af_full, wdf_full, rdf_valid;
   logic [127:0] rdf_dout;

   logic         p0_af_full_o[2], p0_wdf_full_o[2], p0_rdf_valid_o[2];
   logic         p1_af_full_o[2], p1_wdf_full_o[2], p1_rdf_valid_o[2];
   logic [127:0] p0_rdf_dout_o[2], p1_rdf_dout_o[2];
   logic [2:0]   af_cmd_din_o[2];
   logic [30:0]  af_addr_din_o[2];
   logic         af_wr_en_o[2], wdf_wr_en_o[2], rdf_rd_en_o[2], owner_o[2], busy_o[2];
   logic [127:0] wdf_din_o[2];
   logic [15:0]  wdf_mask_din_o[2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      ddr2_arbiter #(.PRIO_RR(g == 0)) u_dut (
         .clk            (clk),
         .rst            (rst),
         .p0_af_cmd_din  (p0_af_cmd_din),
         .p0_af_addr_din (p0_af_addr_din),
         .p0_af_wr_en    (p0_af_wr_en),
         .p0_wdf_din     (p0_wdf_din),
         .p0_wdf_mask_din(p0_wdf_mask_din),
         .p0_wdf_wr_en   (p0_wdf_wr_en),
         .p0_rdf_rd_en   (p0_rdf_rd_en),
         .p0_af_full     (p0_af_full_o[g]),
         .p0_wdf_full    (p0_wdf_full_o[g]),
         .p0_rdf_valid   (p0_rdf_valid_o[g]),
         .p0_rdf_dout    (p0_rdf_dout_o[g]),
         .p1_af_cmd_din  (p1_af_cmd_din),
         .p1_af_addr_din (p1_af_addr_din),
         .p1_af_wr_en    (p1_af_wr_en),
         .p1_wdf_din     (p1_wdf_din),
         .p1_wdf_mask_din(p1_wdf_mask_din),
         .p1_wdf_wr_en   (p1_wdf_wr_en),
         .p1_rdf_rd_en   (p1_rdf_rd_en),
         .p1_af_full     (p1_af_full_o[g]),
         .p1_wdf_full    (p1_wdf_full_o[g]),
         .p1_rdf_valid   (p1_rdf_valid_o[g]),
         .p1_rdf_dout    (p1_rdf_dout_o[g]),
         .af_full        (af_full),
         .wdf_full       (wdf_full),
         .rdf_valid      (rdf_valid),
         .rdf_dout       (rdf_dout),
         .af_cmd_din     (af_cmd_din_o[g]),
         .af_addr_din    (af_addr_din_o[g]),
         .af_wr_en       (af_wr_en_o[g]),
         .wdf_din        (wdf_din_o[g]),
         .wdf_mask_din   (wdf_mask_din_o[g]),
         .wdf_wr_en      (wdf_wr_en_o[g]),
         .rdf_rd_en      (rdf_rd_en_o[g]),
         .owner          (owner_o[g]),
         .busy           (busy_o[g])
      );
   end

   int total = 0;
   int bad   = 0;
   logic m_last[2];
   logic [1:0] won;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Arbitration rule: a lone requester wins; a tie goes to !last (round robin) or port 0.
   function automatic logic exp_win(input logic r0, input logic r1, input bit rr, input logic last);
      if (r0 && r1) return rr ? ~last : 1'b0;
      return r1;
   endfunction

   // Two DDR2 beats starting in RD1; own[k] is the expected owner of instance k.
   task automatic read_beats(input logic [1:0] own, input string tag);
      logic [127:0] d;
      for (int b = 0; b < 2; b++) begin
         d = rnd128();
         rdf_valid = 1'b1;
         rdf_dout = d;
         p0_rdf_rd_en = 1'b1;
         p1_rdf_rd_en = 1'b1;
         settle();
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_v0_k%0d_b%0d", tag, k, b), p0_rdf_valid_o[k], !own[k]);
            chk($sformatf("%s_v1_k%0d_b%0d", tag, k, b), p1_rdf_valid_o[k], own[k]);
            chk($sformatf("%s_pop_k%0d_b%0d", tag, k, b), rdf_rd_en_o[k], 1'b1);
            chk($sformatf("%s_dout_k%0d_b%0d", tag, k, b),
                own[k] ? p1_rdf_dout_o[k] : p0_rdf_dout_o[k], d);
            chk($sformatf("%s_busy_k%0d_b%0d", tag, k, b), busy_o[k], 1'b1);
         end
         tick();
      end
      rdf_valid = 1'b0;
      p0_rdf_rd_en = 1'b0;
      p1_rdf_rd_en = 1'b0;
      settle();
      for (int k = 0; k < 2; k++) chk($sformatf("%s_idle_k%0d", tag, k), busy_o[k], 1'b0);
   endtask

   initial begin
      logic [127:0] d1, d2;
      logic [30:0]  a0, a1;
      logic         r0, r1, w;
      logic [1:0]   v;

      rst = 1'b0;
      {p0_af_cmd_din, p0_af_addr_din, p0_af_wr_en, p0_wdf_din, p0_wdf_mask_din} = '0;
      {p0_wdf_wr_en, p0_rdf_rd_en} = '0;
      {p1_af_cmd_din, p1_af_addr_din, p1_af_wr_en, p1_wdf_din, p1_wdf_mask_din} = '0;
      {p1_wdf_wr_en, p1_rdf_rd_en} = '0;
      {af_full, wdf_full} = '0;
      rdf_valid = 1'b1;
      rdf_dout = rnd128();
      #2;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_busy_k%0d", k), busy_o[k], 1'b0);
         chk($sformatf("rst_owner_k%0d", k), owner_o[k], 1'b0);
         chk($sformatf("rst_afwr_k%0d", k), af_wr_en_o[k], 1'b0);
         chk($sformatf("rst_wdfwr_k%0d", k), wdf_wr_en_o[k], 1'b0);
         chk($sformatf("rst_pop_k%0d", k), rdf_rd_en_o[k], 1'b0);
         chk($sformatf("rst_v0_k%0d", k), p0_rdf_valid_o[k], 1'b0);
         chk($sformatf("rst_v1_k%0d", k), p1_rdf_valid_o[k], 1'b0);
         m_last[k] = 1'b1;
      end
      rdf_valid = 1'b0;
      tick();
      rst = 1'b1;

      // Lone D$ read
      tick();
      p0_af_cmd_din = 3'b001;
      p0_af_addr_din = 31'h100;
      p0_af_wr_en = 1'b1;
      settle();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rd0_afwr_k%0d", k), af_wr_en_o[k], 1'b1);
         chk($sformatf("rd0_cmd_k%0d", k), af_cmd_din_o[k], 3'b001);
         chk($sformatf("rd0_addr_k%0d", k), af_addr_din_o[k], 31'h100);
         chk($sformatf("rd0_wdfwr_k%0d", k), wdf_wr_en_o[k], 1'b0);
         chk($sformatf("rd0_p1full_k%0d", k), p1_af_full_o[k], 1'b1);
         chk($sformatf("rd0_p0full_k%0d", k), p0_af_full_o[k], 1'b0);
         m_last[k] = 1'b0;
      end
      tick();
      p0_af_wr_en = 1'b0;
      settle();
      for (int k = 0; k < 2; k++) chk($sformatf("rd0_owner_k%0d", k), owner_o[k], 1'b0);
      read_beats(2'b00, "rd0");

      // Lone I$ write with a stalled second beat
      d1 = rnd128();
      d2 = rnd128();
      a1 = 31'($urandom);
      p1_af_cmd_din = 3'b000;
      p1_af_addr_din = a1;
      p1_af_wr_en = 1'b1;
      p1_wdf_din = d1;
      p1_wdf_mask_din = 16'h0FFF;
      p1_wdf_wr_en = 1'b1;
      settle();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("wr1_afwr_k%0d", k), af_wr_en_o[k], 1'b1);
         chk($sformatf("wr1_cmd_k%0d", k), af_cmd_din_o[k], 3'b000);
         chk($sformatf("wr1_addr_k%0d", k), af_addr_din_o[k], a1);
         chk($sformatf("wr1_wdfwr_k%0d", k), wdf_wr_en_o[k], 1'b1);
         chk($sformatf("wr1_din_k%0d", k), wdf_din_o[k], d1);
         chk($sformatf("wr1_mask_k%0d", k), wdf_mask_din_o[k], 16'h0FFF);
         chk($sformatf("wr1_p1wfull_k%0d", k), p1_wdf_full_o[k], 1'b0);
         chk($sformatf("wr1_p0afull_k%0d", k), p0_af_full_o[k], 1'b1);
         m_last[k] = 1'b1;
      end
      tick();
      p1_af_wr_en = 1'b0;
      p1_wdf_din = d2;
      wdf_full = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("wr2stall_wdfwr_k%0d_c%0d", k, c), wdf_wr_en_o[k], 1'b0);
            chk($sformatf("wr2stall_busy_k%0d_c%0d", k, c), busy_o[k], 1'b1);
            chk($sformatf("wr2stall_owner_k%0d_c%0d", k, c), owner_o[k], 1'b1);
            chk($sformatf("wr2stall_p1afull_k%0d_c%0d", k, c), p1_af_full_o[k], 1'b1);
            chk($sformatf("wr2stall_p0wfull_k%0d_c%0d", k, c), p0_wdf_full_o[k], 1'b1);
         end
         tick();
      end
      wdf_full = 1'b0;
      settle();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("wr2_wdfwr_k%0d", k), wdf_wr_en_o[k], 1'b1);
         chk($sformatf("wr2_din_k%0d", k), wdf_din_o[k], d2);
         chk($sformatf("wr2_p1wfull_k%0d", k), p1_wdf_full_o[k], 1'b0);
      end
      tick();
      settle();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("wr2_done_busy_k%0d", k), busy_o[k], 1'b0);
         chk($sformatf("wr2_nodup_k%0d", k), wdf_wr_en_o[k], 1'b0);
      end
      p1_wdf_wr_en = 1'b0;

      // Blocked grant while af_full is high
      tick();
      af_full = 1'b1;
      a0 = 31'($urandom);
      p0_af_cmd_din = 3'($urandom_range(7, 1));
      p0_af_addr_din = a0;
      p0_af_wr_en = 1'b1;
      for (int c = 0; c < 5; c++) begin
         settle();
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("blk_afwr_k%0d_c%0d", k, c), af_wr_en_o[k], 1'b0);
            chk($sformatf("blk_busy_k%0d_c%0d", k, c), busy_o[k], 1'b0);
            chk($sformatf("blk_owner_k%0d_c%0d", k, c), owner_o[k], 1'b1);
            chk($sformatf("blk_p0afull_k%0d_c%0d", k, c), p0_af_full_o[k], 1'b1);
         end
         tick();
      end
      af_full = 1'b0;
      settle();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("blk_push_k%0d", k), af_wr_en_o[k], 1'b1);
         chk($sformatf("blk_addr_k%0d", k), af_addr_din_o[k], a0);
         m_last[k] = 1'b0;
      end
      tick();
      p0_af_wr_en = 1'b0;
      settle();
      for (int k = 0; k < 2; k++) chk($sformatf("blk_owner_k%0d", k), owner_o[k], 1'b0);
      read_beats(2'b00, "blk");

      // Fresh reset, then arbitration under tied and random request patterns
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int k = 0; k < 2; k++) m_last[k] = 1'b1;
      for (int n = 0; n < 14; n++) begin
         if (n < 6) begin
            r0 = 1'b1; r1 = 1'b1;
         end else if (n < 8) begin
            r0 = 1'b0; r1 = 1'b1;
         end else begin
            v = 2'($urandom_range(3, 1));
            r0 = v[0]; r1 = v[1];
         end
         a0 = 31'($urandom);
         a1 = ~a0;
         p0_af_cmd_din = 3'($urandom_range(7, 1));
         p1_af_cmd_din = 3'($urandom_range(7, 1));
         p0_af_addr_din = a0;
         p1_af_addr_din = a1;
         p0_af_wr_en = r0;
         p1_af_wr_en = r1;
         settle();
         for (int k = 0; k < 2; k++) begin
            w = exp_win(r0, r1, k == 0, m_last[k]);
            chk($sformatf("arb_afwr_k%0d_n%0d", k, n), af_wr_en_o[k], 1'b1);
            chk($sformatf("arb_addr_k%0d_n%0d", k, n), af_addr_din_o[k], w ? a1 : a0);
            chk($sformatf("arb_cmd_k%0d_n%0d", k, n), af_cmd_din_o[k],
                w ? p1_af_cmd_din : p0_af_cmd_din);
            chk($sformatf("arb_winfull_k%0d_n%0d", k, n),
                w ? p1_af_full_o[k] : p0_af_full_o[k], 1'b0);
            chk($sformatf("arb_winwfull_k%0d_n%0d", k, n),
                w ? p1_wdf_full_o[k] : p0_wdf_full_o[k], 1'b1);
            chk($sformatf("arb_losefull_k%0d_n%0d", k, n),
                w ? p0_af_full_o[k] : p1_af_full_o[k], 1'b1);
            won[k] = w;
            m_last[k] = w;
         end
         tick();
         settle();
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("arb_owner_k%0d_n%0d", k, n), owner_o[k], won[k]);
            chk($sformatf("arb_hold_k%0d_n%0d", k, n), af_wr_en_o[k], 1'b0);
            chk($sformatf("arb_p0full_k%0d_n%0d", k, n), p0_af_full_o[k], 1'b1);
            chk($sformatf("arb_p1full_k%0d_n%0d", k, n), p1_af_full_o[k], 1'b1);
         end
         read_beats(won, $sformatf("arb%0d", n));
      end
      p0_af_wr_en = 1'b0;
      p1_af_wr_en = 1'b0;

      // Reset in RD1, stray beats afterwards, then a normal I$ read
      tick();
      p0_af_cmd_din = 3'b001;
      p0_af_addr_din = 31'($urandom);
      p0_af_wr_en = 1'b1;
      settle();
      for (int k = 0; k < 2; k++) chk($sformatf("mid_afwr_k%0d", k), af_wr_en_o[k], 1'b1);
      tick();
      p0_af_wr_en = 1'b0;
      settle();
      for (int k = 0; k < 2; k++) chk($sformatf("mid_rd1_k%0d", k), busy_o[k], 1'b1);
      rst = 1'b0;
      rdf_valid = 1'b1;
      rdf_dout = rnd128();
      p0_rdf_rd_en = 1'b1;
      p1_rdf_rd_en = 1'b1;
      settle();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("mid_rst_busy_k%0d", k), busy_o[k], 1'b0);
         chk($sformatf("mid_rst_owner_k%0d", k), owner_o[k], 1'b0);
         chk($sformatf("mid_rst_pop_k%0d", k), rdf_rd_en_o[k], 1'b0);
         chk($sformatf("mid_rst_v0_k%0d", k), p0_rdf_valid_o[k], 1'b0);
         m_last[k] = 1'b1;
      end
      tick();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         rdf_dout = rnd128();
         settle();
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("stray_pop_k%0d_c%0d", k, c), rdf_rd_en_o[k], 1'b1);
            chk($sformatf("stray_v0_k%0d_c%0d", k, c), p0_rdf_valid_o[k], 1'b0);
            chk($sformatf("stray_v1_k%0d_c%0d", k, c), p1_rdf_valid_o[k], 1'b0);
            chk($sformatf("stray_busy_k%0d_c%0d", k, c), busy_o[k], 1'b0);
         end
         tick();
      end
      rdf_valid = 1'b0;
      p0_rdf_rd_en = 1'b0;
      p1_rdf_rd_en = 1'b0;
      a1 = 31'($urandom);
      p1_af_cmd_din = 3'($urandom_range(7, 1));
      p1_af_addr_din = a1;
      p1_af_wr_en = 1'b1;
      settle();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("post_afwr_k%0d", k), af_wr_en_o[k], 1'b1);
         chk($sformatf("post_addr_k%0d", k), af_addr_din_o[k], a1);
      end
      tick();
      p1_af_wr_en = 1'b0;
      settle();
      for (int k = 0; k < 2; k++) chk($sformatf("post_owner_k%0d", k), owner_o[k], 1'b1);
      read_beats(2'b11, "post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
